// File: rtl/ft64_fetch_pkg.sv
// Shared types and defaults for the FT64 two-thread fetch scheduler.
package ft64_fetch_pkg;

  typedef logic thrd_t;

  localparam logic [31:0] DEF_RSTPC0       = 32'hFFFC0100;
  localparam logic [31:0] DEF_RSTPC1       = 32'hFFFC0200;
  localparam int unsigned DEF_MISS_TIMEOUT = 255;

  // Code reported to the core's panic logic when a fetch miss hangs.
  localparam logic [3:0]  PANIC_FETCHHANG  = 4'd9;

endpackage

// File: rtl/ft64_fetch_sched_if.sv
// Fetch-scheduler bus: backend/fetch-stage redirects in, I-cache fetch request out.
interface ft64_fetch_sched_if #(
  parameter int AMSB = 31
);
  logic            thread_en;
  logic            freeze;
  logic            fb_ready;
  logic            phit;
  logic [2:0]      insln;
  logic            branchmiss;
  logic            branchmiss_thrd;
  logic [AMSB:0]   misspc;
  logic            redir_v;
  logic            redir_thrd;
  logic [AMSB:0]   redir_pc;
  logic            fetch_v;
  logic            fetch_thrd;
  logic [AMSB:0]   fetch_pc;
  logic            fetch_locked;
  logic [AMSB:0]   pc0;
  logic [AMSB:0]   pc1;
  logic            panic;

  modport master (
    input  thread_en, freeze, fb_ready, phit, insln,
           branchmiss, branchmiss_thrd, misspc,
           redir_v, redir_thrd, redir_pc,
    output fetch_v, fetch_thrd, fetch_pc, fetch_locked, pc0, pc1, panic
  );

  modport slave (
    output thread_en, freeze, fb_ready, phit, insln,
           branchmiss, branchmiss_thrd, misspc,
           redir_v, redir_thrd, redir_pc,
    input  fetch_v, fetch_thrd, fetch_pc, fetch_locked, pc0, pc1, panic
  );

endinterface

// File: rtl/ft64_rr2.sv
// Two-requester round-robin picker: prefers the requester that was not served last.
module ft64_rr2
  import ft64_fetch_pkg::*;
(
  input  logic [1:0] req,
  input  thrd_t      last,
  output thrd_t      grant
);

  // With no other requester pending the previous winner keeps the grant.
  always_comb begin
    grant = last;
    if (req[~last]) grant = ~last;
  end

endmodule

// File: rtl/ft64_fetch_sched.sv
// FT64 two-thread fetch scheduler: per-thread PCs, redirect priority,
// miss lock and hung-miss panic.
//
// state     | meaning
// ST_FETCH  | selected thread free to fetch / switch
// ST_MISS   | selected thread waiting on an I-cache miss, selection frozen
module ft64_fetch_sched
  import ft64_fetch_pkg::*;
#(
  parameter int              AMSB         = 31,
  parameter logic [AMSB:0]   RSTPC0       = DEF_RSTPC0,
  parameter logic [AMSB:0]   RSTPC1       = DEF_RSTPC1,
  parameter int unsigned     MISS_TIMEOUT = DEF_MISS_TIMEOUT
) (
  input  logic                clk,
  input  logic                rst,
  ft64_fetch_sched_if.master  bus
);

  localparam logic [0:0] ST_FETCH = 1'b0;
  localparam logic [0:0] ST_MISS  = 1'b1;
  localparam logic [7:0] MCNT_MAX = 8'(MISS_TIMEOUT);

  logic [AMSB:0] pc0_r, pc1_r;
  thrd_t         sel_r, last_r;
  logic [0:0]    lock_r;
  logic [7:0]    mcnt_r;
  logic          panic_r;

  logic          elig1;
  logic          kill0, kill1, kill_sel;
  logic          fetch_v, fetch_done, miss;
  logic [AMSB:0] insln_x, pc0_nxt, pc1_nxt;
  thrd_t         rr_last, grant, sel_nxt;

  assign elig1    = bus.thread_en;
  assign kill0    = (bus.branchmiss & ~bus.branchmiss_thrd) | (bus.redir_v & ~bus.redir_thrd);
  assign kill1    = (bus.branchmiss &  bus.branchmiss_thrd) | (bus.redir_v &  bus.redir_thrd);
  assign kill_sel = sel_r ? kill1 : kill0;

  assign fetch_v    = ~rst & ~bus.freeze & bus.fb_ready &
                      (~sel_r | elig1 | (lock_r == ST_MISS));
  assign fetch_done = fetch_v & bus.phit & ~kill_sel;
  assign miss       = fetch_v & ~bus.phit & ~kill_sel;

  assign insln_x = {{(AMSB-2){1'b0}}, bus.insln};

  // Branch miss beats fetch-stage redirect, which beats sequential advance.
  always_comb begin
    pc0_nxt = pc0_r;
    if (bus.branchmiss && !bus.branchmiss_thrd)  pc0_nxt = bus.misspc;
    else if (bus.redir_v && !bus.redir_thrd)     pc0_nxt = bus.redir_pc;
    else if (fetch_done && !sel_r)               pc0_nxt = pc0_r + insln_x;
  end

  always_comb begin
    pc1_nxt = pc1_r;
    if (bus.branchmiss && bus.branchmiss_thrd)   pc1_nxt = bus.misspc;
    else if (bus.redir_v && bus.redir_thrd)      pc1_nxt = bus.redir_pc;
    else if (fetch_done && sel_r)                pc1_nxt = pc1_r + insln_x;
  end

  // On a completed fetch the thread just served counts as the last winner.
  assign rr_last = fetch_done ? sel_r : last_r;

  ft64_rr2 u_rr2 (
    .req   ({elig1, 1'b1}),
    .last  (rr_last),
    .grant (grant)
  );

  always_comb begin
    sel_nxt = sel_r;
    if (fetch_done)
      sel_nxt = grant;
    else if (lock_r == ST_FETCH && sel_r && !elig1)
      sel_nxt = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc0_r   <= RSTPC0;
      pc1_r   <= RSTPC1;
      sel_r   <= 1'b0;
      last_r  <= 1'b1;
      lock_r  <= ST_FETCH;
      mcnt_r  <= 8'd0;
      panic_r <= 1'b0;
    end else begin
      pc0_r <= pc0_nxt;
      pc1_r <= pc1_nxt;
      sel_r <= sel_nxt;
      if (fetch_done) last_r <= sel_r;

      if (bus.phit || kill_sel)
        lock_r <= ST_FETCH;
      else if (miss)
        lock_r <= ST_MISS;

      if (bus.phit || kill_sel)
        mcnt_r <= 8'd0;
      else if (fetch_v && lock_r == ST_MISS && mcnt_r != MCNT_MAX)
        mcnt_r <= mcnt_r + 8'd1;

      if (mcnt_r == MCNT_MAX) panic_r <= 1'b1;
    end
  end

  assign bus.fetch_v      = fetch_v;
  assign bus.fetch_thrd   = sel_r;
  assign bus.fetch_pc     = sel_r ? pc1_r : pc0_r;
  assign bus.fetch_locked = (lock_r == ST_MISS);
  assign bus.pc0          = pc0_r;
  assign bus.pc1          = pc1_r;
  assign bus.panic        = panic_r;

endmodule

// File: tb/tb_ft64_fetch_sched.sv
// Directed bench for ft64_fetch_sched: sequential fetch, alternation, miss lock,
// redirect priority, freeze, miss-timeout panic, reset mid-miss and PC wrap.
module tb_ft64_fetch_sched;
  import ft64_fetch_pkg::*;

  logic clk;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  ft64_fetch_sched_if #(.AMSB(31)) bus ();

  ft64_fetch_sched #(
    .AMSB         (31),
    .RSTPC0       (32'hFFFC0100),
    .RSTPC1       (32'hFFFC0200),
    .MISS_TIMEOUT (255)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst                 = 1'b1;
    bus.thread_en       = 1'b0;
    bus.freeze          = 1'b0;
    bus.fb_ready        = 1'b1;
    bus.phit            = 1'b1;
    bus.insln           = 3'd4;
    bus.branchmiss      = 1'b0;
    bus.branchmiss_thrd = 1'b0;
    bus.misspc          = '0;
    bus.redir_v         = 1'b0;
    bus.redir_thrd      = 1'b0;
    bus.redir_pc        = '0;

    tick(); tick();
    chk("rst_fetch_v", bus.fetch_v, 0);
    chk("rst_pc0", bus.pc0, 32'hFFFC0100);
    chk("rst_pc1", bus.pc1, 32'hFFFC0200);
    chk("rst_thrd", bus.fetch_thrd, 0);
    chk("rst_locked", bus.fetch_locked, 0);
    chk("rst_panic", bus.panic, 0);

    // Single thread, insln=4
    rst = 1'b0; #1;
    chk("st_fetch_v", bus.fetch_v, 1);
    chk("st_pc_a", bus.fetch_pc, 32'hFFFC0100);
    tick();
    chk("st_pc_b", bus.fetch_pc, 32'hFFFC0104);
    chk("st_thrd_b", bus.fetch_thrd, 0);
    tick();
    chk("st_pc_c", bus.fetch_pc, 32'hFFFC0108);
    chk("st_thrd_c", bus.fetch_thrd, 0);

    // Two threads alternating, insln=2
    rst = 1'b1; tick();
    rst = 1'b0; bus.thread_en = 1'b1; bus.insln = 3'd2; #1;
    chk("alt_pc_0", bus.fetch_pc, 32'hFFFC0100);
    chk("alt_thrd_0", bus.fetch_thrd, 0);
    tick();
    chk("alt_pc_1", bus.fetch_pc, 32'hFFFC0200);
    chk("alt_thrd_1", bus.fetch_thrd, 1);
    tick();
    chk("alt_pc_2", bus.fetch_pc, 32'hFFFC0102);
    chk("alt_thrd_2", bus.fetch_thrd, 0);
    tick();
    chk("alt_pc_3", bus.fetch_pc, 32'hFFFC0202);
    tick();
    chk("alt_pc_4", bus.fetch_pc, 32'hFFFC0104);
    tick();
    // pc0=0106, pc1=0204, sel=1
    chk("alt_pc_5", bus.fetch_pc, 32'hFFFC0204);

    // Miss on thread 1 for 3 cycles; thread_en drops while locked
    bus.phit = 1'b0; bus.insln = 3'd4;
    tick();
    chk("lk_locked_1", bus.fetch_locked, 1);
    bus.thread_en = 1'b0; #1;
    chk("lk_fetch_v_en0", bus.fetch_v, 1);
    tick();
    chk("lk_thrd_hold", bus.fetch_thrd, 1);
    tick();
    chk("lk_locked_3", bus.fetch_locked, 1);
    chk("lk_pc1_hold", bus.pc1, 32'hFFFC0204);
    bus.phit = 1'b1;
    tick();
    chk("lk_pc1_adv", bus.pc1, 32'hFFFC0208);
    chk("lk_thrd_sw", bus.fetch_thrd, 0);
    chk("lk_unlocked", bus.fetch_locked, 0);
    bus.thread_en = 1'b1;

    // Same-thread branchmiss + redir with phit: misspc wins, no advance
    bus.branchmiss = 1'b1; bus.branchmiss_thrd = 1'b0; bus.misspc = 32'h00001000;
    bus.redir_v = 1'b1; bus.redir_thrd = 1'b0; bus.redir_pc = 32'h00002000;
    tick();
    bus.branchmiss = 1'b0; bus.redir_v = 1'b0;
    chk("bm_pc0", bus.pc0, 32'h00001000);
    chk("bm_thrd", bus.fetch_thrd, 0);
    chk("bm_pc1", bus.pc1, 32'hFFFC0208);

    // Redirect of unselected thread does not disturb current fetch
    bus.insln = 3'd2;
    bus.redir_v = 1'b1; bus.redir_thrd = 1'b1; bus.redir_pc = 32'h00005000;
    tick();
    bus.redir_v = 1'b0;
    chk("un_pc0", bus.pc0, 32'h00001002);
    chk("un_pc1", bus.pc1, 32'h00005000);
    chk("un_thrd", bus.fetch_thrd, 1);

    // Redirects on different threads in the same cycle both apply
    bus.branchmiss = 1'b1; bus.branchmiss_thrd = 1'b0; bus.misspc = 32'h00006000;
    bus.redir_v = 1'b1; bus.redir_thrd = 1'b1; bus.redir_pc = 32'h00007000;
    tick();
    bus.branchmiss = 1'b0; bus.redir_v = 1'b0;
    chk("dt_pc0", bus.pc0, 32'h00006000);
    chk("dt_pc1", bus.pc1, 32'h00007000);
    chk("dt_thrd", bus.fetch_thrd, 1);

    // Freeze with redirect on thread 1; miss must not lock
    bus.freeze = 1'b1; bus.phit = 1'b0;
    bus.redir_v = 1'b1; bus.redir_thrd = 1'b1; bus.redir_pc = 32'h00003000; #1;
    chk("fz_fetch_v", bus.fetch_v, 0);
    tick();
    bus.redir_v = 1'b0;
    chk("fz_pc1", bus.pc1, 32'h00003000);
    chk("fz_pc0", bus.pc0, 32'h00006000);
    chk("fz_locked", bus.fetch_locked, 0);
    bus.freeze = 1'b0; bus.fb_ready = 1'b0; #1;
    chk("fb_fetch_v", bus.fetch_v, 0);
    tick();
    chk("fb_locked", bus.fetch_locked, 0);
    bus.fb_ready = 1'b1;

    // Miss timeout: 256 miss cycles bring the counter to 255
    bus.insln = 3'd4;
    for (int i = 0; i < 256; i++) tick();
    chk("pn_locked", bus.fetch_locked, 1);
    chk("pn_not_yet", bus.panic, 0);
    bus.phit = 1'b1;
    tick();
    chk("pn_set", bus.panic, 1);
    chk("pn_pc1", bus.pc1, 32'h00003004);
    tick(); tick();
    chk("pn_sticky", bus.panic, 1);

    // Reset in the middle of a miss
    bus.phit = 1'b0;
    tick(); tick();
    chk("rm_locked", bus.fetch_locked, 1);
    rst = 1'b1;
    tick();
    chk("rm_unlocked", bus.fetch_locked, 0);
    chk("rm_panic", bus.panic, 0);
    chk("rm_fetch_v", bus.fetch_v, 0);
    rst = 1'b0; bus.phit = 1'b1; bus.thread_en = 1'b0; #1;
    chk("rm_pc", bus.fetch_pc, 32'hFFFC0100);
    chk("rm_thrd", bus.fetch_thrd, 0);

    // PC wraps modulo 2^32
    bus.redir_v = 1'b1; bus.redir_thrd = 1'b0; bus.redir_pc = 32'hFFFFFFFE;
    tick();
    bus.redir_v = 1'b0;
    chk("wr_pc0_a", bus.pc0, 32'hFFFFFFFE);
    tick();
    chk("wr_pc0_b", bus.pc0, 32'h00000002);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
